// File: rtl/sha256_nonce_sweeper.sv
// sha256_nonce_sweeper: Avalon-MM nonce sweeper over NCORES iterative SHA-256 compression cores
// Ports: clk, reset (sync, active-high); chipselect/write/read/address[4:0]/writedata[31:0] slave inputs;
//        readdata[31:0] registered read data (1-cycle latency); irq high while STATUS.done is set.
// sha256_module ports: start pulse loads data_in (word i = bits [32i+31:32i]); done pulses once with
//        digest = {H0..H7} (H0 at [255:224]) after 64 rounds; digest is held until the next start.
module sha256_module (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] data_in,
  output logic [255:0] digest,
  output logic         done
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  logic [31:0] v_q [8], v_d [8], nv [8], w_q [16], w_d [16];
  logic [31:0] t1, t2, ws;
  logic [5:0] rnd_q, rnd_d;
  logic run_q, run_d, done_q, done_d;
  logic [255:0] digest_q, digest_d;
  always_comb begin
    t1 = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25)) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[rnd_q] + w_q[0];
    t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22)) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    nv = '{t1 + t2, v_q[0], v_q[1], v_q[2], v_q[3] + t1, v_q[4], v_q[5], v_q[6]};
    // w_q is a sliding 16-word window: w_q[i] = W[t+i]
    ws = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9] + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    v_d = v_q;
    w_d = w_q;
    rnd_d = rnd_q;
    run_d = run_q;
    done_d = 1'b0;
    digest_d = digest_q;
    if (start) begin
      v_d = IV;
      for (int i = 0; i < 16; i++) w_d[i] = data_in[32*i +: 32];
      rnd_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      v_d = nv;
      for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
      w_d[15] = ws;
      rnd_d = rnd_q + 6'd1;
      if (rnd_q == 6'd63) begin
        run_d = 1'b0;
        done_d = 1'b1;
        for (int j = 0; j < 8; j++) digest_d[255-32*j -: 32] = IV[j] + nv[j];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '{default: '0};
      w_q <= '{default: '0};
      rnd_q <= '0;
      run_q <= 1'b0;
      done_q <= 1'b0;
      digest_q <= '0;
    end else begin
      v_q <= v_d;
      w_q <= w_d;
      rnd_q <= rnd_d;
      run_q <= run_d;
      done_q <= done_d;
      digest_q <= digest_d;
    end
  end
  assign digest = digest_q;
  assign done = done_q;
endmodule

module sha256_nonce_sweeper #(
  parameter int NCORES = 4,
  parameter int NONCE_IDX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [4:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  localparam int IW = NCORES > 1 ? $clog2(NCORES) : 1;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] block_q [16], block_d [16];
  logic [31:0] first_q, first_d, last_q, last_d, res_nonce_q, res_nonce_d;
  logic [31:0] hash_cnt_q, hash_cnt_d, rdata_q, rdata_d, cnt_add;
  logic [8:0] tz_q, tz_d, tzc;
  logic [255:0] res_hash_q, res_hash_d, mask;
  logic done_q, done_d, found_q, found_d, exh_q, exh_d;
  logic [32:0] cur_q, cur_d;
  logic [32:0] nonce [NCORES];
  logic [NCORES-1:0] active_q, active_d, dflag_q, dflag_d, core_start, core_done, hit;
  logic [255:0] core_digest [NCORES];
  logic [511:0] core_data [NCORES];
  logic [IW-1:0] win;
  logic [4:0] hidx;
  logic wr, ctrl_wr, start, abort, clr, busy, any_hit, core_rst;
  assign wr = chipselect & write;
  assign ctrl_wr = wr & (address == 5'd16);
  assign abort = ctrl_wr & writedata[1];
  assign start = ctrl_wr & writedata[0] & ~writedata[1];
  assign clr = ctrl_wr & writedata[2] & ~writedata[1] & ~writedata[0];
  assign busy = state_q == LAUNCH || state_q == WAIT || state_q == CHECK;
  assign core_rst = reset | abort;
  assign tzc = tz_q > 9'd256 ? 9'd256 : tz_q;
  // top tzc digest bits must be zero; tzc=256 shifts everything out so only the all-zero digest matches
  assign mask = ~({256{1'b1}} >> tzc);
  assign hidx = address - 5'd22;
  always_comb begin
    cnt_add = '0;
    win = '0;
    any_hit = 1'b0;
    for (int k = 0; k < NCORES; k++) begin
      nonce[k] = cur_q + 33'(k);
      core_start[k] = state_q == LAUNCH && nonce[k] <= {1'b0, last_q};
      for (int i = 0; i < 16; i++) core_data[k][32*i +: 32] = i == NONCE_IDX ? nonce[k][31:0] : block_q[i];
      hit[k] = active_q[k] && (core_digest[k] & mask) == '0;
    end
    // descending scan so the lowest-index hit is the one left standing
    for (int k = NCORES - 1; k >= 0; k--) begin
      cnt_add = cnt_add + 32'(active_q[k]);
      if (hit[k]) begin
        win = IW'(k);
        any_hit = 1'b1;
      end
    end
  end
  for (genvar g = 0; g < NCORES; g++) begin : g_core
    sha256_module u_core (
      .clk(clk), .reset(core_rst), .start(core_start[g]), .data_in(core_data[g]),
      .digest(core_digest[g]), .done(core_done[g])
    );
  end
  always_comb begin
    state_d = state_q;
    block_d = block_q;
    first_d = first_q;
    last_d = last_q;
    tz_d = tz_q;
    res_nonce_d = res_nonce_q;
    res_hash_d = res_hash_q;
    hash_cnt_d = hash_cnt_q;
    done_d = done_q;
    found_d = found_q;
    exh_d = exh_q;
    cur_d = cur_q;
    active_d = active_q;
    dflag_d = dflag_q;
    rdata_d = '0;
    if (chipselect && read) begin
      case (address)
        5'd17: rdata_d = {28'd0, exh_q, found_q, done_q, busy};
        5'd18: rdata_d = first_q;
        5'd19: rdata_d = last_q;
        5'd20: rdata_d = {23'd0, tz_q};
        5'd21: rdata_d = res_nonce_q;
        5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29: rdata_d = res_hash_q[{hidx[2:0], 5'd0} +: 32];
        5'd30: rdata_d = hash_cnt_q;
        default: rdata_d = address[4] ? 32'd0 : block_q[address[3:0]];
      endcase
    end
    if (wr && !busy) begin
      if (!address[4]) block_d[address[3:0]] = writedata;
      if (address == 5'd18) first_d = writedata;
      if (address == 5'd19) last_d = writedata;
      if (address == 5'd20) tz_d = writedata[8:0];
    end
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          hash_cnt_d = '0;
          res_nonce_d = '0;
          res_hash_d = '0;
          done_d = 1'b0;
          found_d = 1'b0;
          exh_d = 1'b0;
          cur_d = {1'b0, first_q};
          state_d = first_q > last_q ? DONE : LAUNCH;
          done_d = first_q > last_q;
          exh_d = first_q > last_q;
        end else if (clr && state_q == DONE) begin
          state_d = IDLE;
          done_d = 1'b0;
        end
      end
      LAUNCH: begin
        active_d = core_start;
        dflag_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        dflag_d = dflag_q | (core_done & active_q);
        if ((dflag_d & active_q) == active_q) state_d = CHECK;
      end
      CHECK: begin
        hash_cnt_d = hash_cnt_q + cnt_add;
        if (any_hit) begin
          res_nonce_d = nonce[win][31:0];
          res_hash_d = core_digest[win];
          found_d = 1'b1;
          done_d = 1'b1;
          state_d = DONE;
        end else if (cur_q + 33'(NCORES) > {1'b0, last_q}) begin
          exh_d = 1'b1;
          done_d = 1'b1;
          state_d = DONE;
        end else begin
          cur_d = cur_q + 33'(NCORES);
          state_d = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      done_d = 1'b0;
      found_d = 1'b0;
      exh_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      block_q <= '{default: '0};
      first_q <= '0;
      last_q <= '0;
      tz_q <= '0;
      res_nonce_q <= '0;
      res_hash_q <= '0;
      hash_cnt_q <= '0;
      rdata_q <= '0;
      done_q <= 1'b0;
      found_q <= 1'b0;
      exh_q <= 1'b0;
      cur_q <= '0;
      active_q <= '0;
      dflag_q <= '0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      first_q <= first_d;
      last_q <= last_d;
      tz_q <= tz_d;
      res_nonce_q <= res_nonce_d;
      res_hash_q <= res_hash_d;
      hash_cnt_q <= hash_cnt_d;
      rdata_q <= rdata_d;
      done_q <= done_d;
      found_q <= found_d;
      exh_q <= exh_d;
      cur_q <= cur_d;
      active_q <= active_d;
      dflag_q <= dflag_d;
    end
  end
  assign readdata = rdata_q;
  assign irq = done_q;
endmodule
